// File: rtl/hazard_fwd_ctrl.sv
// rtl/hazard_fwd_ctrl.sv - ID-stage hazard detection, stall/flush and operand forwarding selects
// Optional stall statistics counter enabled by defining HFC_STATS_EN.
module hazard_fwd_ctrl #(
    parameter int REG_BITS = 5,
    parameter int CNT_W    = 32
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [REG_BITS-1:0] i_id_rs,
    input  logic [REG_BITS-1:0] i_id_rt,
    input  logic                i_id_uses_rt,
    input  logic                i_id_branch,
    input  logic                i_id_branch_taken,
    input  logic [REG_BITS-1:0] i_ex_rd,
    input  logic                i_ex_regwrite,
    input  logic                i_ex_memread,
    input  logic [REG_BITS-1:0] i_mem_rd,
    input  logic                i_mem_regwrite,
    input  logic                i_mem_memread,
    output logic                o_stall,
    output logic                o_flush_ifid,
    output logic [1:0]          o_ex_fwd_a,
    output logic [1:0]          o_ex_fwd_b,
    output logic                o_id_fwd_a,
    output logic                o_id_fwd_b
`ifdef HFC_STATS_EN
    ,
    output logic [CNT_W-1:0]    o_stall_count
`endif
);

    typedef enum logic {ST_RUN = 1'b0, ST_LDBR = 1'b1} state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic w_ex_wr_rs, w_ex_wr_rt, w_mem_wr_rs, w_mem_wr_rt;
    logic w_load_use, w_br_alu, w_br_mem_load, w_br_ex_load;
    logic w_run_stall;
    logic [1:0] r_ex_fwd_a, r_ex_fwd_b;
    logic [1:0] w_fwd_a_nxt, w_fwd_b_nxt;

    // Register 0 is hardwired, so a write to it never creates a dependency.
    assign w_ex_wr_rs  = i_ex_regwrite  && (i_ex_rd  == i_id_rs) && (i_id_rs != '0);
    assign w_ex_wr_rt  = i_ex_regwrite  && (i_ex_rd  == i_id_rt) && (i_id_rt != '0);
    assign w_mem_wr_rs = i_mem_regwrite && (i_mem_rd == i_id_rs) && (i_id_rs != '0);
    assign w_mem_wr_rt = i_mem_regwrite && (i_mem_rd == i_id_rt) && (i_id_rt != '0);

    assign w_load_use    = i_ex_memread && (w_ex_wr_rs || (i_id_uses_rt && w_ex_wr_rt));
    assign w_br_alu      = i_id_branch && !i_ex_memread && (w_ex_wr_rs || w_ex_wr_rt);
    assign w_br_mem_load = i_id_branch && i_mem_memread && (w_mem_wr_rs || w_mem_wr_rt);
    assign w_br_ex_load  = i_id_branch && i_ex_memread && (w_ex_wr_rs || w_ex_wr_rt);
    assign w_run_stall   = w_load_use || w_br_alu || w_br_mem_load || w_br_ex_load;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = ST_RUN;
        case (r_state)
            ST_RUN:  w_state_nxt = w_br_ex_load ? ST_LDBR : ST_RUN;
            ST_LDBR: w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        o_stall = 1'b0;
        case (r_state)
            ST_RUN:  o_stall = w_run_stall;
            ST_LDBR: o_stall = 1'b1;
            default: o_stall = 1'b0;
        endcase
    end

    assign o_flush_ifid = i_id_branch && i_id_branch_taken && !o_stall;
    assign o_id_fwd_a   = i_id_branch && w_mem_wr_rs && !i_mem_memread;
    assign o_id_fwd_b   = i_id_branch && w_mem_wr_rt && !i_mem_memread;

    // A load in EX cannot supply 10; the load-use stall turns that case into a bubble.
    always_comb begin
        w_fwd_a_nxt = 2'b00;
        w_fwd_b_nxt = 2'b00;
        if (!o_stall) begin
            if (w_ex_wr_rs && !i_ex_memread) begin
                w_fwd_a_nxt = 2'b10;
            end else if (w_mem_wr_rs) begin
                w_fwd_a_nxt = 2'b01;
            end
            if (i_id_uses_rt) begin
                if (w_ex_wr_rt && !i_ex_memread) begin
                    w_fwd_b_nxt = 2'b10;
                end else if (w_mem_wr_rt) begin
                    w_fwd_b_nxt = 2'b01;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ex_fwd_a <= 2'b00;
            r_ex_fwd_b <= 2'b00;
        end else begin
            r_ex_fwd_a <= w_fwd_a_nxt;
            r_ex_fwd_b <= w_fwd_b_nxt;
        end
    end

    assign o_ex_fwd_a = r_ex_fwd_a;
    assign o_ex_fwd_b = r_ex_fwd_b;

`ifdef HFC_STATS_EN
    logic [CNT_W-1:0] r_stall_count;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_stall_count <= '0;
        end else if (o_stall && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + CNT_W'(1);
        end
    end

    assign o_stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb/tb_hazard_fwd_ctrl.sv - self-checking bench for hazard_fwd_ctrl
module tb_hazard_fwd_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rd = '0, mem_rd = '0;
    logic       uses_rt = 0, br = 0, tk = 0, exw = 0, exm = 0, memw = 0, memm = 0;
    logic       stall, flush, ida, idb;
    logic [1:0] fa, fb;
`ifdef HFC_STATS_EN
    logic [31:0] cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_fwd_ctrl dut (
        .i_clk(clk), .i_reset(rst),
        .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_uses_rt(uses_rt),
        .i_id_branch(br), .i_id_branch_taken(tk),
        .i_ex_rd(ex_rd), .i_ex_regwrite(exw), .i_ex_memread(exm),
        .i_mem_rd(mem_rd), .i_mem_regwrite(memw), .i_mem_memread(memm),
        .o_stall(stall), .o_flush_ifid(flush),
        .o_ex_fwd_a(fa), .o_ex_fwd_b(fb),
        .o_id_fwd_a(ida), .o_id_fwd_b(idb)
`ifdef HFC_STATS_EN
        , .o_stall_count(cnt)
`endif
    );

    typedef struct {
        logic [4:0] rs, rt;
        logic       ur, b, t;
        logic [4:0] erd;
        logic       ew, em;
        logic [4:0] mrd;
        logic       mw, mm;
        logic       e_stall, e_flush, e_ida, e_idb;
        logic [1:0] e_fa, e_fb;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                         input logic b, input logic t,
                         input logic [4:0] erd, input logic ew, input logic em,
                         input logic [4:0] mrd, input logic mw, input logic mm);
        id_rs = rs; id_rt = rt; uses_rt = ur; br = b; tk = t;
        ex_rd = erd; exw = ew; exm = em; mem_rd = mrd; memw = mw; memm = mm;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    function automatic bit writes(input bit w, input logic [4:0] rd, input logic [4:0] r);
        return w && (rd == r) && (r != 0);
    endfunction

    // Reference model state: pending second stall cycle for a branch behind a load.
    bit m_ldbr;
    logic [1:0] m_fa, m_fb;
    int m_cnt;

    function automatic logic [1:0] sel(input bit ex_hit, input bit ex_load, input bit mem_hit);
        if (ex_hit && !ex_load) return 2'b10;
        if (mem_hit) return 2'b01;
        return 2'b00;
    endfunction

    initial begin
        vecs[0]  = '{3, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0,  0, 0, 0, 0, 2'b10, 2'b00};
        vecs[1]  = '{1, 4, 1, 0, 0, 4, 1, 1, 0, 0, 0,  1, 0, 0, 0, 2'b00, 2'b00};
        vecs[2]  = '{7, 0, 0, 0, 0, 7, 1, 0, 7, 1, 0,  0, 0, 0, 0, 2'b10, 2'b00};
        vecs[3]  = '{0, 0, 1, 0, 0, 0, 1, 1, 0, 1, 0,  0, 0, 0, 0, 2'b00, 2'b00};
        vecs[4]  = '{9, 0, 1, 1, 1, 0, 0, 0, 9, 1, 0,  0, 1, 1, 0, 2'b01, 2'b00};
        vecs[5]  = '{1, 6, 1, 1, 1, 6, 1, 0, 0, 0, 0,  1, 0, 0, 0, 2'b00, 2'b00};
        vecs[6]  = '{8, 0, 1, 1, 1, 0, 0, 0, 8, 1, 1,  1, 0, 0, 0, 2'b00, 2'b00};
        vecs[7]  = '{1, 2, 1, 0, 0, 0, 0, 0, 2, 1, 1,  0, 0, 0, 0, 2'b00, 2'b01};
        vecs[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2'b00, 2'b00};
        vecs[9]  = '{1, 4, 0, 0, 0, 4, 1, 1, 0, 0, 0,  0, 0, 0, 0, 2'b00, 2'b00};
        vecs[10] = '{5, 6, 1, 1, 0, 0, 0, 0, 6, 1, 0,  0, 0, 0, 1, 2'b00, 2'b01};
        vecs[11] = '{3, 3, 1, 1, 1, 3, 0, 0, 3, 0, 0,  0, 1, 0, 0, 2'b00, 2'b00};

        do_reset();
        chk("reset_stall", stall, 0);
        chk("reset_flush", flush, 0);
        chk("reset_idfwd", {ida, idb}, 0);
        chk("reset_exfwd", {fa, fb}, 0);
`ifdef HFC_STATS_EN
        chk("reset_cnt", cnt, 0);
`endif

        for (int i = 0; i < 12; i++) begin
            do_reset();
            drive(vecs[i].rs, vecs[i].rt, vecs[i].ur, vecs[i].b, vecs[i].t,
                  vecs[i].erd, vecs[i].ew, vecs[i].em, vecs[i].mrd, vecs[i].mw, vecs[i].mm);
            #2;
            chk($sformatf("v%0d_stall", i), stall, vecs[i].e_stall);
            chk($sformatf("v%0d_flush", i), flush, vecs[i].e_flush);
            chk($sformatf("v%0d_ida", i), ida, vecs[i].e_ida);
            chk($sformatf("v%0d_idb", i), idb, vecs[i].e_idb);
            tick();
            chk($sformatf("v%0d_fa", i), fa, vecs[i].e_fa);
            chk($sformatf("v%0d_fb", i), fb, vecs[i].e_fb);
        end

        // Load-use: one bubble, then WB forwarding.
        do_reset();
        drive(1, 4, 1, 0, 0, 4, 1, 1, 0, 0, 0); #2;
        chk("lu_stall0", stall, 1);
        tick();
        chk("lu_fb_bubble", fb, 2'b00);
        drive(1, 4, 1, 0, 0, 0, 0, 0, 4, 1, 1); #2;
        chk("lu_stall1", stall, 0);
        tick();
        chk("lu_fb_wb", fb, 2'b01);

        // Branch after load: two stall cycles, then resolve and flush once.
        do_reset();
        drive(5, 0, 1, 1, 1, 5, 1, 1, 0, 0, 0); #2;
        chk("ldbr_c0_stall", stall, 1);
        chk("ldbr_c0_flush", flush, 0);
        tick();
        drive(5, 0, 1, 1, 1, 0, 0, 0, 5, 1, 1); #2;
        chk("ldbr_c1_stall", stall, 1);
        chk("ldbr_c1_flush", flush, 0);
        tick();
        idle(); br = 1; tk = 1; id_rs = 5; uses_rt = 1; #2;
        chk("ldbr_c2_stall", stall, 0);
        chk("ldbr_c2_idfwd", {ida, idb}, 0);
        chk("ldbr_c2_flush", flush, 1);
        tick();
        idle(); #2;
        chk("ldbr_c3_flush", flush, 0);

        // Reset in LDBR abandons the second stall.
        do_reset();
        drive(5, 0, 1, 1, 1, 5, 1, 1, 0, 0, 0);
        tick();
        idle(); #2;
        chk("rst_pre_stall", stall, 1);
        rst = 1'b1; #1;
        chk("rst_ldbr_stall", stall, 0);
        chk("rst_ldbr_fwd", {fa, fb}, 0);
`ifdef HFC_STATS_EN
        chk("rst_ldbr_cnt", cnt, 0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;

`ifdef HFC_STATS_EN
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(4, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0); tick();
            idle(); tick();
        end
        drive(5, 0, 1, 1, 0, 5, 1, 1, 0, 0, 0); tick();
        idle(); tick();
        tick();
        chk("stats_count", cnt, 5);
`endif

        // Randomized run against a rule-level model.
        do_reset();
        m_ldbr = 0; m_fa = 0; m_fb = 0; m_cnt = 0;
        for (int n = 0; n < 400; n++) begin
            bit ers, ert, mrs, mrt, lu, bra, brm, bre, ebr, estall;
            chk("rnd_fa", fa, m_fa);
            chk("rnd_fb", fb, m_fb);
            drive($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1));
            #2;
            ers = writes(exw, ex_rd, id_rs);   ert = writes(exw, ex_rd, id_rt);
            mrs = writes(memw, mem_rd, id_rs); mrt = writes(memw, mem_rd, id_rt);
            lu  = exm && (ers || (uses_rt && ert));
            bra = br && !exm && (ers || ert);
            brm = br && memm && (mrs || mrt);
            bre = br && exm && (ers || ert);
            estall = m_ldbr || lu || bra || brm || bre;
            chk("rnd_stall", stall, estall);
            chk("rnd_flush", flush, br && tk && !estall);
            chk("rnd_ida", ida, br && mrs && !memm);
            chk("rnd_idb", idb, br && mrt && !memm);
            m_fa = estall ? 2'b00 : sel(ers, exm, mrs);
            m_fb = (estall || !uses_rt) ? 2'b00 : sel(ert, exm, mrt);
            if (estall) m_cnt++;
            m_ldbr = !m_ldbr && bre;
            tick();
        end
`ifdef HFC_STATS_EN
        chk("rnd_cnt", cnt, m_cnt);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_ctrl.md
# hazard_fwd_ctrl

- Pipeline hazard controller that generates the select lines consumed by the datapath's 2:1/3:1 operand multiplexers.
- Each cycle it compares the ID-stage source registers against EX/MEM destinations and produces:
  - registered EX-stage forwarding selects;
  - ID-stage branch-comparator forwarding selects;
  - load-use and branch-dependency stalls;
  - the IF/ID flush on a taken branch.
- Sits beside the ID stage and drives PC write-enable, IF/ID hold/flush, ID/EX bubble insertion and the operand mux selects.

## Interface
Parameters:
- REG_BITS, 5, register-specifier width
- CNT_W, 32, stall-counter width (used only with HFC_STATS_EN)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- id_rs, id_rt  input  REG_BITS  source registers of the instruction in ID
- id_uses_rt  input  1  instruction in ID reads rt
- id_branch  input  1  instruction in ID is a branch, compared in ID
- id_branch_taken  input  1  ID comparator result (valid only with id_branch)
- ex_rd  input  REG_BITS  destination of the instruction in EX
- ex_regwrite, ex_memread  input  1  control bits of the instruction in EX
- mem_rd  input  REG_BITS  destination of the instruction in MEM
- mem_regwrite, mem_memread  input  1  control bits of the instruction in MEM
- stall  output  1  hold PC and IF/ID; zero ID/EX control (bubble)
- flush_ifid  output  1  clear IF/ID at next edge
- ex_fwd_a, ex_fwd_b  output  2  registered EX operand selects: 00 regfile, 01 WB result, 10 MEM ALU result
- id_fwd_a, id_fwd_b  output  1  branch operand select: 1 = MEM ALU result
- stall_count  output  CNT_W  stall cycles since reset (present only with HFC_STATS_EN)

## Operation
Matching rules:
- "X writes r" means X_regwrite & X_rd == r & r != 0.
- rt matches count only when id_uses_rt (ID rules) or id_branch (branch rules).

Stall conditions, RUN state (combinational):
- Load-use: EX is memread and EX writes rs or rt.
- Branch-ALU: id_branch and EX writes rs/rt with ex_memread = 0.
- Branch-MEM-load: id_branch and MEM is memread and MEM writes rs/rt.
- Branch-EX-load: id_branch and EX is memread and EX writes rs/rt. This asserts stall and moves to LDBR.

FSM:
- States are RUN and LDBR.
- LDBR asserts stall unconditionally and returns to RUN at the next edge.
- Total stall for a branch after a load is 2 cycles.

Outputs:
- flush_ifid = id_branch & id_branch_taken & ~stall (combinational).
- id_fwd_a = id_branch & MEM writes rs & ~mem_memread. id_fwd_b is the same using rt.

EX forwarding registers, captured at each edge for the instruction entering EX:
- If stall = 1, load 00/00 (bubble).
- Otherwise ex_fwd_a = 10 if EX writes rs and ~ex_memread; else 01 if MEM writes rs; else 00. ex_fwd_b is the same using rt.
- EX has priority over MEM.
- A load in EX never produces 10; load-use stall covers that case.

Reset:
- FSM → RUN.
- ex_fwd_a/b = 00, stall_count = 0.
- Combinational outputs follow their inputs immediately; with all inputs 0, stall = 0, flush_ifid = 0, id_fwd = 0.
- Reset asserted mid-LDBR abandons the second stall cycle.

## Timing
- stall, flush_ifid and id_fwd_* are combinational, same cycle as their inputs.
- ex_fwd_* have 1-cycle latency and are valid throughout the cycle the instruction is in EX.
- Load-use adds 1 stall cycle.
- Branch after ALU op adds 1. Branch after load adds 2 (RUN→LDBR→RUN).
- Branch after load already in MEM adds 1.
- Simultaneous stall and taken branch: stall wins, flush_ifid = 0. The branch re-evaluates after the stall.
- Register 0 never forwards or stalls.

## Configuration
HFC_STATS_EN:
- Defined: stall_count is present. It increments on every cycle with stall = 1, saturates at all-ones and clears on reset.
- Undefined: the port and counter are absent, with no other behavioural change.

## Test plan
- add $3 in EX, ID uses rs=3 → stall = 0; next cycle ex_fwd_a = 10, ex_fwd_b = 00.
- lw $4 in EX, ID rt=4, id_uses_rt=1 → stall = 1 for exactly 1 cycle; ex_fwd_b = 00 during the bubble; then 01 the cycle after.
- lw $5 in EX, beq on $5 in ID → stall = 1 for 2 cycles (LDBR observed); then id_fwd = 0 and the branch resolves; if taken, flush_ifid = 1 for 1 cycle.
- EX and MEM both write $7, ID rs=7 → ex_fwd_a = 10 (EX priority); destination $0 in EX/MEM → no forward, no stall.
- Assert reset during LDBR → stall drops to 0 immediately, ex_fwd = 00, stall_count = 0.
- With HFC_STATS_EN, 3 load-use events plus 1 branch-after-load → stall_count = 5.
